// File: rtl/cacheline_adapter_pkg.sv
// rtl/cacheline_adapter_pkg.sv - shared constants and types for the cacheline burst adapter
package cacheline_adapter_pkg;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, DONE} state_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - splits a cacheline request into a beat burst and reassembles read lines
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_addr,
  input  logic        line_read,
  input  logic        line_write,
  input  line_t       line_wdata,
  output logic        line_ready,
  output line_t       line_rdata,
  output logic        line_valid,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output beat_t       bmem_wdata,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  beat_t       bmem_rdata,
  input  logic        bmem_rvalid
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [31:0]             addr_q;
  logic [31:0]             aligned;
  beat_t [BEATS-1:0]       wbeat_q;
  beat_t [BEATS-1:0]       buf_q;
  logic                    unused_addr_bits;

  assign cnt_nxt          = cnt + CNT_W'(1);
  assign aligned          = {line_addr[31:5], 5'b0};
  assign unused_addr_bits = ^line_addr[4:0];

  // Every output is registered; each transition loads the values the next state presents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wbeat_q    <= '0;
      buf_q      <= '0;
      line_ready <= 1'b1;
      line_valid <= 1'b0;
      line_rdata <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (line_write) begin
            state      <= WR;
            cnt        <= '0;
            addr_q     <= aligned;
            wbeat_q    <= line_wdata;
            line_ready <= 1'b0;
            bmem_addr  <= aligned;
            bmem_write <= 1'b1;
            bmem_wdata <= line_wdata[BEAT_W-1:0];
          end else if (line_read) begin
            state      <= RD_REQ;
            addr_q     <= aligned;
            line_ready <= 1'b0;
            bmem_addr  <= aligned;
            bmem_read  <= 1'b1;
          end
        end
        WR: begin
          if (bmem_ready) begin
            if (cnt == LAST) begin
              state      <= DONE;
              bmem_write <= 1'b0;
              bmem_addr  <= '0;
              bmem_wdata <= '0;
              line_valid <= 1'b1;
              line_rdata <= '0;
            end else begin
              cnt        <= cnt_nxt;
              bmem_wdata <= wbeat_q[cnt_nxt];
            end
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            state     <= RD_DATA;
            cnt       <= '0;
            bmem_read <= 1'b0;
            bmem_addr <= '0;
          end
        end
        RD_DATA: begin
          // Beats tagged for another line belong to someone else and are dropped.
          if (bmem_rvalid && bmem_raddr == addr_q) begin
            buf_q[cnt] <= bmem_rdata;
            if (cnt == LAST) begin
              state      <= DONE;
              line_valid <= 1'b1;
              line_rdata <= {bmem_rdata, buf_q[BEATS-2:0]};
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          line_valid <= 1'b0;
          line_rdata <= '0;
          line_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - randomized self-checking bench for cacheline_adapter
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_addr;
  logic        line_read, line_write;
  line_t       line_wdata, line_rdata;
  logic        line_ready, line_valid;
  logic [31:0] bmem_addr, bmem_raddr;
  logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  beat_t       bmem_wdata, bmem_rdata;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_ready(line_ready), .line_rdata(line_rdata),
    .line_valid(line_valid), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations gathered by the drivers; the test tasks judge them.
  beat_t       got_beats[$];
  logic [31:0] got_addr[$];
  int          wcyc, stall_chg, busy_bad, rd_seen, rcmd, extra_rd, early_valid, wr_seen;
  logic [31:0] cmd_addr;
  logic        done_valid, done_ready, done_wr, after_valid, after_ready;
  line_t       done_rdata;
  logic        hold_read, both_req;

  logic        sc_v[$];
  logic [31:0] sc_a[$];
  beat_t       sc_d[$];

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic line_t model_line(input logic [31:0] al);
    line_t l = '0;
    int n = 0;
    for (int i = 0; i < sc_v.size(); i++)
      if (sc_v[i] && sc_a[i] == al && n < BEATS) begin
        l[n*BEAT_W +: BEAT_W] = sc_d[i];
        n++;
      end
    return l;
  endfunction

  task automatic push_beat(input logic v, input logic [31:0] a, input beat_t d);
    sc_v.push_back(v); sc_a.push_back(a); sc_d.push_back(d);
  endtask

  task automatic clear_script();
    sc_v.delete(); sc_a.delete(); sc_d.delete();
  endtask

  task automatic random_script(input logic [31:0] al);
    clear_script();
    for (int i = 0; i < BEATS; i++) begin
      int junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        if ($urandom_range(0, 1) == 0) push_beat(1'b0, $urandom, {$urandom, $urandom});
        else push_beat(1'b1, al + 32'h20 * 32'($urandom_range(1, 8)), {$urandom, $urandom});
      end
      push_beat(1'b1, al, {$urandom, $urandom});
    end
  endtask

  task automatic run_write(input logic [31:0] a, input line_t d, input int mode);
    beat_t prev_d;
    logic  prev_stall;
    line_write = 1'b1; line_read = both_req; line_addr = a; line_wdata = d;
    tick();
    line_write = 1'b0; line_read = hold_read;
    got_beats.delete(); got_addr.delete();
    wcyc = 0; stall_chg = 0; busy_bad = 0; rd_seen = 0; prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 200 && got_beats.size() < BEATS; c++) begin
      case (mode)
        0:       bmem_ready = 1'b1;
        1:       bmem_ready = (c % 2 == 0);
        default: bmem_ready = 1'($urandom_range(0, 1));
      endcase
      if (bmem_read) rd_seen++;
      if (line_ready !== 1'b0 || line_valid !== 1'b0) busy_bad++;
      if (bmem_write) begin
        wcyc++;
        if (prev_stall && bmem_wdata !== prev_d) stall_chg++;
        if (bmem_ready) begin
          got_beats.push_back(bmem_wdata);
          got_addr.push_back(bmem_addr);
        end
        prev_stall = !bmem_ready;
        prev_d = bmem_wdata;
      end
      tick();
    end
    bmem_ready = 1'b0; line_read = 1'b0;
    done_valid = line_valid; done_rdata = line_rdata; done_ready = line_ready; done_wr = bmem_write;
    if (bmem_read) rd_seen++;
    tick();
    after_valid = line_valid; after_ready = line_ready;
  endtask

  task automatic run_read(input logic [31:0] a, input int stall);
    logic acc;
    line_read = 1'b1; line_write = 1'b0; line_addr = a;
    tick();
    line_read = 1'b0;
    rcmd = 0; cmd_addr = '0; acc = 1'b0; extra_rd = 0; early_valid = 0; wr_seen = 0;
    for (int c = 0; c < 100 && !acc; c++) begin
      bmem_ready = (c >= stall);
      if (bmem_write) wr_seen++;
      if (bmem_read) begin
        rcmd++;
        cmd_addr = bmem_addr;
        acc = bmem_ready;
      end
      tick();
    end
    bmem_ready = 1'b0;
    for (int i = 0; i < sc_v.size(); i++) begin
      bmem_rvalid = sc_v[i]; bmem_raddr = sc_a[i]; bmem_rdata = sc_d[i];
      if (bmem_read) extra_rd++;
      if (line_valid) early_valid++;
      if (bmem_write) wr_seen++;
      tick();
    end
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    done_valid = line_valid; done_rdata = line_rdata; done_ready = line_ready;
    tick();
    after_valid = line_valid; after_ready = line_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0; line_write = 1'b1; line_addr = 32'h1234_5678; line_wdata = rand_line();
    tick(); tick();
    total++; if (line_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", line_ready); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", line_valid); end
    total++; if (bmem_write !== 1'b0 || bmem_read !== 1'b0) begin bad++; $display("FAIL reset_cmd got=%0b%0b exp=00", bmem_write, bmem_read); end
    total++; if (bmem_addr !== 32'h0 || bmem_wdata !== '0) begin bad++; $display("FAIL reset_bmem got=%h/%h exp=0/0", bmem_addr, bmem_wdata); end
    total++; if (line_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", line_rdata); end
    line_write = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_write();
    for (int s = 0; s < 5; s++) begin
      logic [31:0] a;
      line_t d;
      int mode;
      if (s == 0) begin
        a = 32'h1eceb020;
        d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        mode = 0;
      end else begin
        a = $urandom; d = rand_line(); mode = (s == 1) ? 1 : 2;
      end
      run_write(a, d, mode);
      total++; if (got_beats.size() != BEATS) begin bad++; $display("FAIL wr%0d_count got=%0d exp=%0d", s, got_beats.size(), BEATS); end
      for (int i = 0; i < got_beats.size() && i < BEATS; i++) begin
        total++; if (got_beats[i] !== d[i*BEAT_W +: BEAT_W]) begin bad++; $display("FAIL wr%0d_beat%0d got=%h exp=%h", s, i, got_beats[i], d[i*BEAT_W +: BEAT_W]); end
        total++; if (got_addr[i] !== {a[31:5], 5'b0}) begin bad++; $display("FAIL wr%0d_addr%0d got=%h exp=%h", s, i, got_addr[i], {a[31:5], 5'b0}); end
      end
      total++; if (stall_chg != 0) begin bad++; $display("FAIL wr%0d_stall_hold got=%0d exp=0", s, stall_chg); end
      total++; if (busy_bad != 0) begin bad++; $display("FAIL wr%0d_busy got=%0d exp=0", s, busy_bad); end
      if (mode != 2) begin
        total++; if (wcyc != (mode == 0 ? 4 : 7)) begin bad++; $display("FAIL wr%0d_cycles got=%0d exp=%0d", s, wcyc, mode == 0 ? 4 : 7); end
      end
      total++; if (done_valid !== 1'b1 || done_wr !== 1'b0 || done_ready !== 1'b0) begin bad++; $display("FAIL wr%0d_done got=v%0b w%0b r%0b exp=v1 w0 r0", s, done_valid, done_wr, done_ready); end
      total++; if (done_rdata !== '0) begin bad++; $display("FAIL wr%0d_rdata got=%h exp=0", s, done_rdata); end
      total++; if (after_valid !== 1'b0 || after_ready !== 1'b1) begin bad++; $display("FAIL wr%0d_after got=v%0b r%0b exp=v0 r1", s, after_valid, after_ready); end
    end
  endtask

  task automatic test_read();
    for (int s = 0; s < 5; s++) begin
      logic [31:0] a, al;
      int stall;
      line_t exp;
      if (s == 0) begin
        a = 32'h1eceb047; stall = 2; al = {a[31:5], 5'b0};
        clear_script();
        push_beat(1'b1, al, 64'd1); push_beat(1'b1, al, 64'd2); push_beat(1'b0, al, 64'd99);
        push_beat(1'b1, al, 64'd3); push_beat(1'b1, al, 64'd4);
      end else if (s == 1) begin
        a = 32'h0000_1240; stall = 0; al = a;
        clear_script();
        push_beat(1'b1, 32'h0, 64'hDEAD_BEEF_DEAD_BEEF);
        for (int i = 0; i < BEATS; i++) push_beat(1'b1, al, {$urandom, $urandom});
      end else begin
        a = $urandom; stall = $urandom_range(0, 3); al = {a[31:5], 5'b0};
        random_script(al);
      end
      exp = model_line(al);
      run_read(a, stall);
      total++; if (rcmd != stall + 1) begin bad++; $display("FAIL rd%0d_cmd_cycles got=%0d exp=%0d", s, rcmd, stall + 1); end
      total++; if (cmd_addr !== al) begin bad++; $display("FAIL rd%0d_cmd_addr got=%h exp=%h", s, cmd_addr, al); end
      total++; if (extra_rd != 0 || wr_seen != 0) begin bad++; $display("FAIL rd%0d_extra_cmd got=%0d/%0d exp=0/0", s, extra_rd, wr_seen); end
      total++; if (early_valid != 0) begin bad++; $display("FAIL rd%0d_early_valid got=%0d exp=0", s, early_valid); end
      total++; if (done_valid !== 1'b1 || done_ready !== 1'b0) begin bad++; $display("FAIL rd%0d_done got=v%0b r%0b exp=v1 r0", s, done_valid, done_ready); end
      total++; if (done_rdata !== exp) begin bad++; $display("FAIL rd%0d_line got=%h exp=%h", s, done_rdata, exp); end
      total++; if (after_valid !== 1'b0 || after_ready !== 1'b1) begin bad++; $display("FAIL rd%0d_after got=v%0b r%0b exp=v0 r1", s, after_valid, after_ready); end
    end
  endtask

  task automatic test_reset_mid_burst();
    line_t d = rand_line();
    line_t exp;
    line_write = 1'b1; line_addr = 32'h0000_0800; line_wdata = d;
    tick();
    line_write = 1'b0; bmem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; bmem_ready = 1'b0;
    tick();
    total++; if (line_ready !== 1'b1 || bmem_write !== 1'b0) begin bad++; $display("FAIL mid_reset_state got=r%0b w%0b exp=r1 w0", line_ready, bmem_write); end
    total++; if (bmem_addr !== 32'h0 || bmem_wdata !== '0) begin bad++; $display("FAIL mid_reset_bmem got=%h/%h exp=0/0", bmem_addr, bmem_wdata); end
    rst = 1'b1;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h100; bmem_rdata = {$urandom, $urandom};
    tick();
    bmem_rvalid = 1'b0;
    total++; if (line_ready !== 1'b1 || bmem_read !== 1'b0 || line_valid !== 1'b0) begin bad++; $display("FAIL mid_stray_beat got=r%0b rd%0b v%0b exp=r1 rd0 v0", line_ready, bmem_read, line_valid); end
    clear_script();
    for (int i = 0; i < BEATS; i++) push_beat(1'b1, 32'h100, {$urandom, $urandom});
    exp = model_line(32'h100);
    run_read(32'h100, 0);
    total++; if (rcmd != 1 || wr_seen != 0) begin bad++; $display("FAIL mid_read_cmds got=rd%0d wr%0d exp=rd1 wr0", rcmd, wr_seen); end
    total++; if (done_valid !== 1'b1 || done_rdata !== exp) begin bad++; $display("FAIL mid_read_line got=v%0b %h exp=v1 %h", done_valid, done_rdata, exp); end
  endtask

  task automatic test_busy_ignore();
    for (int s = 0; s < 2; s++) begin
      line_t d = rand_line();
      int idle_bad = 0;
      hold_read = (s == 0); both_req = (s == 1);
      run_write($urandom, d, 2);
      hold_read = 1'b0; both_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (bmem_read !== 1'b0 || line_ready !== 1'b1) idle_bad++;
        tick();
      end
      total++; if (rd_seen != 0) begin bad++; $display("FAIL busy%0d_read_cmd got=%0d exp=0", s, rd_seen); end
      total++; if (got_beats.size() != BEATS) begin bad++; $display("FAIL busy%0d_count got=%0d exp=%0d", s, got_beats.size(), BEATS); end
      for (int i = 0; i < got_beats.size() && i < BEATS; i++) begin
        total++; if (got_beats[i] !== d[i*BEAT_W +: BEAT_W]) begin bad++; $display("FAIL busy%0d_beat%0d got=%h exp=%h", s, i, got_beats[i], d[i*BEAT_W +: BEAT_W]); end
      end
      total++; if (done_valid !== 1'b1) begin bad++; $display("FAIL busy%0d_done got=%0b exp=1", s, done_valid); end
      total++; if (idle_bad != 0) begin bad++; $display("FAIL busy%0d_not_queued got=%0d exp=0", s, idle_bad); end
    end
  endtask

  initial begin
    rst = 1'b0; line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    hold_read = 1'b0; both_req = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_reset_mid_burst();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
